// File: rtl/nrisc_pkg.sv
// Shared definitions for the nrisc core datapath: default register-file
// geometry and the clear-engine state encoding.
package nrisc_pkg;

  localparam int NRISC_TAM  = 16;
  localparam int NRISC_NREG = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } clr_state_t;

endpackage

// File: rtl/regfile_rdport.sv
// Combinational read port: register mux, optional write-data forwarding and
// hardwired-zero R0 masking of both data and busy.
module regfile_rdport #(
  parameter int TAM     = 16,
  parameter int NREG    = 16,
  parameter bit ZERO_R0 = 1'b0,
  localparam int SELW   = $clog2(NREG)
) (
  input  logic [SELW-1:0] sel,
  input  logic [TAM-1:0]  regs [NREG],
  input  logic [NREG-1:0] busy_vec,
  input  logic            byp_valid,
  input  logic [SELW-1:0] byp_sel,
  input  logic [TAM-1:0]  byp_data,
  output logic [TAM-1:0]  data,
  output logic            busy
);

  always_comb begin
    data = regs[sel];
    busy = busy_vec[sel];
    if (byp_valid && (byp_sel == sel)) data = byp_data;
    // R0 masking wins over forwarding so a dropped R0 write is never visible.
    if (ZERO_R0 && (sel == '0)) begin
      data = '0;
      busy = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with one write port, two combinational read ports, a per-register
// busy scoreboard and a one-register-per-cycle clear engine.
module regfile_scoreboard import nrisc_pkg::*; #(
  parameter int TAM     = NRISC_TAM,
  parameter int NREG    = NRISC_NREG,
  parameter bit ZERO_R0 = 1'b0,
  parameter bit BYPASS  = 1'b1,
  localparam int SELW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [SELW-1:0] wr_sel,
  input  logic [TAM-1:0]  wr_data,
  input  logic [SELW-1:0] sel_a,
  output logic [TAM-1:0]  out_a,
  input  logic [SELW-1:0] sel_b,
  output logic [TAM-1:0]  out_b,
  output logic            busy_a,
  output logic            busy_b,
  input  logic            rsv_en,
  input  logic [SELW-1:0] rsv_sel,
  output logic            rsv_ok,
  input  logic            clr_req,
  output logic            clr_busy,
  output logic            clr_done
);

  // Handshake: rsv_en is a request, rsv_ok is its same-cycle grant; a reservation
  // takes effect at the edge only when both are high. No stall, no retry.
  clr_state_t      state, state_next;
  logic [SELW-1:0] idx;
  logic [TAM-1:0]  regs [NREG];
  logic [NREG-1:0] busy, busy_next;
  logic            idle, wr_legal, byp_valid;

  assign idle      = (state == IDLE);
  assign wr_legal  = wr_en && idle && !(ZERO_R0 && (wr_sel == '0));
  assign rsv_ok    = rsv_en && idle && !busy[rsv_sel] && !(ZERO_R0 && (rsv_sel == '0));
  assign byp_valid = BYPASS && wr_legal;
  assign clr_busy  = (state != IDLE);
  assign clr_done  = (state == DONE);

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (clr_req) state_next = SWEEP;
      SWEEP:   if (idx == SELW'(NREG - 1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Reservation is applied after writeback so a same-cycle pair leaves busy set.
  always_comb begin
    busy_next = busy;
    if (wr_legal) busy_next[wr_sel] = 1'b0;
    if (rsv_ok) busy_next[rsv_sel] = 1'b1;
    if (state == SWEEP) busy_next[idx] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      idx   <= '0;
      busy  <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      state <= state_next;
      busy  <= busy_next;
      if (state == IDLE) idx <= '0;
      else if (state == SWEEP) idx <= idx + SELW'(1);
      if (wr_legal) regs[wr_sel] <= wr_data;
      if (state == SWEEP) regs[idx] <= '0;
    end
  end

  regfile_rdport #(.TAM(TAM), .NREG(NREG), .ZERO_R0(ZERO_R0)) u_rd_a (
    .sel(sel_a), .regs(regs), .busy_vec(busy), .byp_valid(byp_valid),
    .byp_sel(wr_sel), .byp_data(wr_data), .data(out_a), .busy(busy_a)
  );

  regfile_rdport #(.TAM(TAM), .NREG(NREG), .ZERO_R0(ZERO_R0)) u_rd_b (
    .sel(sel_b), .regs(regs), .busy_vec(busy), .byp_valid(byp_valid),
    .byp_sel(wr_sel), .byp_data(wr_data), .data(out_b), .busy(busy_b)
  );

endmodule
